h264_chroma_feeder: RTL and testbench
=====================================

# h264_chroma_feeder

Chroma macroblock source for the 8x8 chroma intra-prediction stage. Accepts one macroblock of Cb and Cr pixels (2×64 bytes, 32 words) from the upstream pixel loader, buffers it, and transmits it as a gapless 32-word STROBEI/DATAI burst when the intra stage raises READYI. It also drives the NEWLINE and NEWSLICE sidebands. It is the transmitting end of the intra stage's input interface.

## Interface
- BURSTGAP, 2: minimum idle cycles between the last STROBEI of one burst and the first of the next.
- CLK2  in  1  clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- WSTROBE  in  1  upstream write; one pixel word per cycle.
- WDATA  in  32  four pixels; [31:24] is the leftmost pixel.
- SLICEI  in  1  sampled with word 0: the MB starts a slice.
- LINEI  in  1  sampled with word 0: the MB starts an MB row.
- WREADY  out  1  a bank is free for writing. WSTROBE is legal only while WREADY is high.
- READYI  in  1  the intra stage can accept a macroblock.
- STROBEI  out  1  DATAI valid.
- DATAI  out  32  pixel word to the intra stage.
- NEWSLICE  out  1  pulse concurrent with the first STROBEI of a slice-start MB.
- NEWLINE  out  1  pulse concurrent with the first STROBEI of a row-start MB.

## Operation
- **Word order** (write and read, identical):
  - Cb rows 0–7, two words per row (left half, then right half): words 0–15.
  - Cr rows 0–7 in the same way: words 16–31.
- **Write side**
  - A 5-bit counter `wcnt` and a bank pointer `wbank`.
  - Each accepted WSTROBE writes bank[wbank][wcnt] and then increments `wcnt`.
  - At word 31 the bank's full flag is set, `wcnt` wraps to 0 and `wbank` toggles.
  - WREADY = not full[wbank].
  - WSTROBE while WREADY is low is ignored and `wcnt` is unchanged.
- **Read FSM**
  - IDLE → ARM when full[rbank] && READYI: issue read address 0, latch the bank's SLICE/LINE flags.
  - ARM → BURST: address increments each cycle; STROBEI is high for 32 consecutive cycles.
  - BURST → GAP after word 31 is presented: clear full[rbank], toggle `rbank`, load the gap counter with BURSTGAP.
  - GAP → IDLE when the gap counter reaches 0. With BURSTGAP=0, GAP lasts 0 cycles and the next IDLE check happens immediately.
- **READYI** is sampled only in IDLE. Once a burst starts it runs to completion regardless of READYI.
- **Simultaneous events**
  - Write completion on one bank and burst completion on the other in the same cycle: both flags update independently.
  - A write into a bank is never allowed while that bank is being read (it is full).

## Timing
- **Reset values:** STROBEI=0, DATAI=0, NEWSLICE=0, NEWLINE=0, WREADY=0. Both banks empty, wcnt=0, wbank=rbank=0, FSM in IDLE.
- WREADY rises on the first cycle after RESET deasserts.
- **Burst latency:** READYI sampled high at edge N with a full bank → STROBEI high for edges N+2 … N+33. The extra cycle is the synchronous RAM read.
- **Write-to-read:** the earliest burst start is the edge after word 31 is written (full flag registered).
- **Burst spacing:** back-to-back bursts are separated by at least BURSTGAP+2 idle cycles (GAP + IDLE sample + ARM).
- **Reset mid-operation:**
  - STROBEI is low on the next cycle.
  - A partial write is discarded and both banks become empty.
  - The intra stage must be reset with RESET or NEWSLICE.

## Configuration
- `CHROMA_FEEDER_DOUBLE_BUFFER_EN`
  - **Defined:** two banks (ping-pong). Upstream loads MB n+1 while MB n streams.
  - **Undefined:** a single bank; `wbank` and `rbank` are fixed at 0. WREADY stays low from word 31 written until the cycle after the last STROBEI. Burst latency and order are unchanged.

## Structure
- Package `h264_chroma_pkg`:
  - MB_WORDS=32 and CB_WORDS=16.
  - `pixword_t` (logic [31:0]).
  - `feed_state_t` enum {IDLE, ARM, BURST, GAP}.
- Sub-module `h264_chroma_bank`: 32×32 single-write/single-read RAM with synchronous read, one instance per bank.

## Test plan
- Write words 0x00010203+i·0x04040404 (i=0..31) with READYI held high → exactly 32 consecutive STROBEI cycles starting 2 cycles after READYI is sampled; DATAI matches in order.
- SLICEI=1, LINEI=0 on word 0 → NEWSLICE=1 with the first STROBEI only, NEWLINE=0 throughout.
- Double buffer: write MB A, then MB B during A's burst → WREADY stays high. A third MB sees WREADY=0 until A's burst ends. Bursts are separated by ≥ BURSTGAP+2 cycles.
- READYI=0 with a full bank for 50 cycles → no STROBEI. Raise READYI → burst at +2. Drop READYI mid-burst → burst still delivers all 32 words.
- WSTROBE while WREADY=0 → data ignored; the next MB's contents are exact.
- RESET at burst word 10 → STROBEI=0 next cycle, WREADY=1 the cycle after RESET deasserts, no residual burst.

Source files
------------

// File: rtl/h264_chroma_pkg.sv
// Shared types and sizes for the chroma macroblock feeder.
package h264_chroma_pkg;

    localparam int MB_WORDS = 32;
    localparam int CB_WORDS = 16;

    typedef logic [31:0] pixword_t;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        BURST,
        GAP
    } feed_state_t;

endpackage

// File: rtl/h264_chroma_bank.sv
// One macroblock of chroma storage: 32x32 RAM, single write port, registered read port.
module h264_chroma_bank
    import h264_chroma_pkg::*;
(
    input  logic       i_clk2,
    input  logic       i_reset,
    input  logic       i_we,
    input  logic [4:0] i_waddr,
    input  pixword_t   i_wdata,
    input  logic       i_re,
    input  logic [4:0] i_raddr,
    output pixword_t   o_rdata
);

    pixword_t r_mem [MB_WORDS];
    pixword_t r_rdata;

    // NOTE: the storage array is deliberately left without reset so it maps onto a RAM macro.
    always_ff @(posedge i_clk2) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk2) begin
        if (i_reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/h264_chroma_feeder.sv
// Buffers one chroma MB (Cb then Cr, 32 words) and streams it as a gapless burst to the intra stage.
// CHROMA_FEEDER_DOUBLE_BUFFER_EN selects ping-pong banks; otherwise a single bank is used.
module h264_chroma_feeder
    import h264_chroma_pkg::*;
#(
    parameter int BURSTGAP = 2
) (
    input  logic     i_clk2,
    input  logic     i_reset,
    input  logic     i_wstrobe,
    input  pixword_t i_wdata,
    input  logic     i_slicei,
    input  logic     i_linei,
    output logic     o_wready,
    input  logic     i_readyi,
    output logic     o_strobei,
    output pixword_t o_datai,
    output logic     o_newslice,
    output logic     o_newline
);

`ifdef CHROMA_FEEDER_DOUBLE_BUFFER_EN
    localparam int NBANK = 2;
`else
    localparam int NBANK = 1;
`endif
    localparam logic       BANK_TOGGLE = (NBANK == 2);
    localparam logic [7:0] GAP_LOAD    = 8'(BURSTGAP);

    logic [1:0]  r_full, r_slice, r_line;
    logic [4:0]  r_wcnt;
    logic        r_wbank, r_rbank;
    feed_state_t r_state;
    logic [5:0]  r_raddr;
    logic [7:0]  r_gap;
    logic        r_slice_lat, r_line_lat;

    logic        w_wr_acc, w_wr_last, w_start, w_rd_done, w_rd_en, w_wbank_nxt;
    logic [1:0]  w_full_nxt;
    pixword_t    w_rdata [2];

    assign w_wr_acc  = i_wstrobe && o_wready;
    assign w_wr_last = w_wr_acc && (r_wcnt == 5'(MB_WORDS - 1));
    assign w_start   = (r_state == IDLE) && r_full[r_rbank] && i_readyi;
    assign w_rd_done = (r_state == BURST) && (r_raddr == 6'(MB_WORDS));
    assign w_rd_en   = ((r_state == ARM) || (r_state == BURST)) && !r_raddr[5];

    // Fill and drain may hit different banks in the same cycle; each flag updates on its own.
    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        w_full_nxt  = r_full;
        w_wbank_nxt = r_wbank;
        if (w_wr_last) begin
            w_full_nxt[r_wbank] = 1'b1;
            w_wbank_nxt         = r_wbank ^ BANK_TOGGLE;
        end
        if (w_rd_done) begin
            w_full_nxt[r_rbank] = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_clk2) begin
        if (i_reset) begin
            r_full   <= '0;
            r_slice  <= '0;
            r_line   <= '0;
            r_wcnt   <= '0;
            r_wbank  <= 1'b0;
            o_wready <= 1'b0;
        end else begin
            r_full   <= w_full_nxt;
            r_wbank  <= w_wbank_nxt;
            o_wready <= !w_full_nxt[w_wbank_nxt];
            if (w_wr_acc) begin
                r_wcnt <= r_wcnt + 5'd1;
                if (r_wcnt == 5'd0) begin
                    r_slice[r_wbank] <= i_slicei;
                    r_line[r_wbank]  <= i_linei;
                end
            end
        end
    end

    always_ff @(posedge i_clk2) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_raddr     <= '0;
            r_gap       <= '0;
            r_rbank     <= 1'b0;
            r_slice_lat <= 1'b0;
            r_line_lat  <= 1'b0;
            o_strobei   <= 1'b0;
            o_newslice  <= 1'b0;
            o_newline   <= 1'b0;
        end else begin
            o_newslice <= 1'b0;
            o_newline  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state     <= ARM;
                        r_raddr     <= '0;
                        r_slice_lat <= r_slice[r_rbank];
                        r_line_lat  <= r_line[r_rbank];
                    end
                end
                ARM: begin
                    // Word 0 leaves the RAM register on this edge, so strobe and sidebands rise with it.
                    r_state    <= BURST;
                    r_raddr    <= r_raddr + 6'd1;
                    o_strobei  <= 1'b1;
                    o_newslice <= r_slice_lat;
                    o_newline  <= r_line_lat;
                end
                BURST: begin
                    if (w_rd_done) begin
                        o_strobei <= 1'b0;
                        r_rbank   <= r_rbank ^ BANK_TOGGLE;
                        r_gap     <= GAP_LOAD;
                        r_state   <= (BURSTGAP == 0) ? IDLE : GAP;
                    end else begin
                        r_raddr <= r_raddr + 6'd1;
                    end
                end
                GAP: begin
                    if (r_gap <= 8'd1) begin
                        r_state <= IDLE;
                    end else begin
                        r_gap <= r_gap - 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        if (b < NBANK) begin : g_ram
            h264_chroma_bank u_bank (
                .i_clk2  (i_clk2),
                .i_reset (i_reset),
                .i_we    (w_wr_acc && (r_wbank == 1'(b))),
                .i_waddr (r_wcnt),
                .i_wdata (i_wdata),
                .i_re    (w_rd_en && (r_rbank == 1'(b))),
                .i_raddr (r_raddr[4:0]),
                .o_rdata (w_rdata[b])
            );
        end else begin : g_none
            assign w_rdata[b] = '0;
        end
    end

    assign o_datai = w_rdata[r_rbank];

endmodule

// File: tb/tb_h264_chroma_feeder.sv
// Self-checking bench for h264_chroma_feeder: timing-rule model plus directed literal checks.
module tb_h264_chroma_feeder;
    import h264_chroma_pkg::*;

    localparam int BURSTGAP = 2;
`ifdef CHROMA_FEEDER_DOUBLE_BUFFER_EN
    localparam int NBANK = 2;
`else
    localparam int NBANK = 1;
`endif

    logic        clk2 = 1'b0;
    logic        reset = 1'b1;
    logic        wstrobe = 1'b0, slicei = 1'b0, linei = 1'b0, readyi = 1'b0;
    logic [31:0] wdata = '0;
    logic        wready, strobei, newslice, newline;
    logic [31:0] datai;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk2 = ~clk2;

    h264_chroma_feeder #(.BURSTGAP(BURSTGAP)) dut (
        .i_clk2     (clk2),
        .i_reset    (reset),
        .i_wstrobe  (wstrobe),
        .i_wdata    (wdata),
        .i_slicei   (slicei),
        .i_linei    (linei),
        .o_wready   (wready),
        .i_readyi   (readyi),
        .o_strobei  (strobei),
        .o_datai    (datai),
        .o_newslice (newslice),
        .o_newline  (newline)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a FIFO of completed MBs, each burst occupying fixed cycle offsets from its start edge.
    typedef struct packed {
        logic              slice;
        logic              line;
        logic [31:0][31:0] w;
    } mb_t;

    mb_t         mbq[$];
    mb_t         cur, strm;
    int          cur_n = 0, start_c = 0, nxt_ok = 0, last_strobe_c = -1;
    bit          active = 0, chk_data = 0;
    logic        m_wready = 1'b0, prev_strobe = 1'b0;
    logic        e_strobe = 1'b0, e_ns = 1'b0, e_nl = 1'b0;
    logic [31:0] e_data = '0;

    // Inputs change 1 time unit after negedge, so at negedge they still show what the last posedge sampled.
    initial forever begin
        @(negedge clk2);
        cyc++;
        if (reset) begin
            mbq.delete();
            cur_n = 0; active = 0; nxt_ok = 0; last_strobe_c = -1;
            m_wready = 1'b0; e_strobe = 1'b0; e_ns = 1'b0; e_nl = 1'b0;
            e_data = '0; chk_data = 1;
        end else begin
            if (active && cyc == start_c + 33) begin
                active = 0;
                void'(mbq.pop_front());
            end
            if (!active && cyc >= nxt_ok && mbq.size() > 0 && readyi) begin
                active = 1; start_c = cyc; strm = mbq[0];
                nxt_ok = cyc + 34 + BURSTGAP;
            end
            if (wstrobe && m_wready) begin
                if (cur_n == 0) begin
                    cur.slice = slicei;
                    cur.line  = linei;
                end
                cur.w[cur_n] = wdata;
                cur_n++;
                if (cur_n == 32) begin
                    mbq.push_back(cur);
                    cur_n = 0;
                end
            end
            m_wready = (mbq.size() < NBANK);
            e_strobe = active && cyc >= start_c + 1 && cyc <= start_c + 32;
            e_data   = '0;
            if (e_strobe) e_data = strm.w[cyc - start_c - 1];
            e_ns     = active && cyc == start_c + 1 && strm.slice;
            e_nl     = active && cyc == start_c + 1 && strm.line;
            chk_data = e_strobe;
        end
        check("strobei", strobei, e_strobe);
        check("wready", wready, m_wready);
        check("newslice", newslice, e_ns);
        check("newline", newline, e_nl);
        if (chk_data) check("datai", datai, e_data);
        if (!reset && strobei === 1'b1 && prev_strobe === 1'b0 && last_strobe_c >= 0)
            check("burst_gap_ok", 32'((cyc - last_strobe_c - 1) >= BURSTGAP + 2), 32'd1);
        if (strobei === 1'b1) last_strobe_c = cyc;
        if (reset) last_strobe_c = -1;
        prev_strobe = strobei;
    end

    task automatic step();
        @(negedge clk2);
        #1;
    endtask

    task automatic write_mb(input logic [31:0] base, input logic [31:0] inc,
                            input logic sl, input logic ln);
        for (int i = 0; i < 32; i++) begin
            int guard = 0;
            while (wready !== 1'b1 && guard < 500) begin
                step();
                guard++;
            end
            if (guard >= 500) begin
                check("wready_timeout", wready, 1);
                wstrobe = 1'b0;
                return;
            end
            wstrobe = 1'b1;
            wdata   = base + 32'(i) * inc;
            slicei  = (i == 0) ? sl : 1'b0;
            linei   = (i == 0) ? ln : 1'b0;
            step();
        end
        wstrobe = 1'b0; slicei = 1'b0; linei = 1'b0;
    endtask

    // Returns the number of cycles until STROBEI is seen (bounded).
    task automatic wait_strobe(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (strobei !== 1'b1 && n < 200);
        if (n >= 200) check("strobe_timeout", strobei, 1);
    endtask

    task automatic drain();
        int guard = 0;
        readyi = 1'b1;
        while ((mbq.size() > 0 || active) && guard < 1000) begin
            step();
            guard++;
        end
        check("drain_done", 32'(mbq.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, cnt;
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("wready_after_reset", wready, 1);

        // Basic burst with SLICEI on word 0 and READYI held high.
        readyi = 1'b1;
        write_mb(32'h00010203, 32'h04040404, 1'b1, 1'b0);
        check("t1_wready_after_fill", wready, (NBANK == 1) ? 32'd0 : 32'd1);
        wait_strobe(n);
        check("t1_latency", n, 2);
        check("t1_word0", datai, 32'h00010203);
        check("t1_newslice", newslice, 1);
        check("t1_newline", newline, 0);
        cnt = 0;
        while (strobei === 1'b1 && cnt < 100) begin
            if (cnt == 31) check("t1_word31", datai, 32'h7C7D7E7F);
            cnt++;
            step();
        end
        check("t1_len", cnt, 32);
        drain();

        // READYI low with full bank(s), ignored writes while WREADY is low.
        readyi = 1'b0;
        for (int m = 0; m < NBANK; m++)
            write_mb(32'hA0000000 + 32'(m) * 32'h100, 32'h00000011, 1'b0, 1'b1);
        cnt = 0;
        repeat (50) begin
            step();
            if (strobei === 1'b1) cnt++;
        end
        check("t2_no_strobe", cnt, 0);
        check("t3_wready_low", wready, 0);
        wstrobe = 1'b1;
        repeat (10) begin
            wdata = $urandom;
            step();
        end
        wstrobe = 1'b0;
        readyi = 1'b1;
        wait_strobe(n);
        check("t2_latency", n, 2);
        check("t2_word0", datai, 32'hA0000000);
        check("t2_newline", newline, 1);
        cnt = 0;
        while (strobei === 1'b1 && cnt < 100) begin
            if (cnt == 5) readyi = 1'b0;
            cnt++;
            step();
        end
        check("t2_len_after_drop", cnt, 32);
        drain();
        write_mb(32'h11223344, 32'h01010101, 1'b0, 1'b0);
        wait_strobe(n);
        check("t3_word0_clean", datai, 32'h11223344);
        drain();

`ifdef CHROMA_FEEDER_DOUBLE_BUFFER_EN
        // Ping-pong: B written during A's burst, C waits for A to finish.
        readyi = 1'b1;
        write_mb(32'hB0000000, 32'h00000003, 1'b1, 1'b1);
        write_mb(32'hC0000000, 32'h00000005, 1'b0, 1'b0);
        check("t4_wready_both_full", wready, 0);
        write_mb(32'hD0000000, 32'h00000007, 1'b0, 1'b1);
        drain();
`endif

        // Reset in the middle of a burst.
        readyi = 1'b1;
        write_mb(32'h5A5A0000, 32'h00000001, 1'b1, 1'b1);
        wait_strobe(n);
        repeat (10) step();
        check("t5_word10", datai, 32'h5A5A000A);
        reset = 1'b1;
        step();
        check("t5_strobe_low", strobei, 0);
        check("t5_datai_zero", datai, 0);
        reset = 1'b0;
        step();
        check("t5_wready", wready, 1);
        cnt = 0;
        repeat (60) begin
            step();
            if (strobei === 1'b1) cnt++;
        end
        check("t5_no_residual", cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
